ili9341_spi_receiver: RTL
=========================

Name: ili9341_spi_receiver

Overview:
Receive-side model of an ILI9341 panel's 4-wire SPI interface. It decodes the byte stream our display drivers emit (CS, SCK, MOSI, D/C) and tracks the column/page window. It converts RAMWR pixel bytes into linear framebuffer writes. It serves as the display endpoint in simulation and as a frame-capture front end on hardware loopback.

Parameters:
COLS, 240, panel width in pixels; full-window column end = COLS-1
ROWS, 320, panel height in pixels; full-window page end = ROWS-1
SYNC_STAGES, 2, synchronizer flops on each SPI input
LOW_BYTE_FIRST, 1, 1: first RAMWR byte of a pixel is pixData[7:0]; 0: first byte is [15:8]

Ports:
CLK_I  in  1  system clock; the only clock
RST_I  in  1  synchronous, active-high reset
tftChipSelect  in  1  SPI chip select, active low
tftSck  in  1  SPI clock, mode 0 (sample on rising edge)
tftMosi  in  1  SPI data, MSB first
dataCtrl  in  1  0 = command byte, 1 = data byte; sampled with bit 0
pixWe  out  1  one-cycle pixel write strobe
pixAddr  out  17  row*COLS + col
pixData  out  16  RGB565 pixel
cmdStrobe  out  1  one-cycle pulse per command byte received
cmdByte  out  8  last command byte; held until the next command
frameDone  out  1  one-cycle pulse with the pixWe of the window's last pixel
byteAbort  out  1  one-cycle pulse when CS rises with 1-7 bits shifted

Behaviour:
- Reset: all outputs 0; window = full (col 0..COLS-1, row 0..ROWS-1); cursor (0,0); FSM IDLE; bit count 0.
- Inputs pass through SYNC_STAGES flops. A SCK rising edge is detected from the synchronized samples.
- Input timing: SCK high and low each >= 2 CLK_I periods.
- CS high: bit counter and shifter clear.
- CS rising with bit count 1-7: byteAbort pulses and the partial byte is discarded. The FSM state is unaffected.
- On each detected rising edge with CS low: shift in MOSI. On the 8th bit: latch the byte and D/C, and pulse an internal byteValid one cycle later.
- Latency: cmdStrobe/pixWe assert exactly 2 CLK_I cycles after the cycle in which the 8th synchronized rising edge is detected.
- Command byte (D/C = 0): accepted in any state. It cancels any partial parameter or pixel sequence; the window is unchanged and the half pixel is dropped. It pulses cmdStrobe and loads cmdByte.
- Command dispatch:
  - 0x2A (CASET) -> COL_PARAMS
  - 0x2B (PASET) -> PAGE_PARAMS
  - 0x2C (RAMWR) -> cursor = (startCol, startRow), then PIX_FIRST
  - 0x01 (SWRESET) -> window = full, then IDLE
  - any other command -> SKIP
- FSM states:
  - IDLE, SKIP: data bytes are ignored.
  - COL_PARAMS / PAGE_PARAMS: count 4 data bytes {S[15:8], S[7:0], E[15:8], E[7:0]}. On the 4th byte, commit start/end only if S <= E and E < COLS (or ROWS); otherwise discard. Then go to IDLE. Further data bytes are ignored.
  - PIX_FIRST: hold the byte, go to PIX_SECOND.
  - PIX_SECOND: assemble the 16-bit pixel per LOW_BYTE_FIRST, pulse pixWe with the current address, advance the cursor, return to PIX_FIRST.
- Cursor advance:
  - col == endCol -> col = startCol, and the row advances.
  - row == endRow at that point -> row = startRow and frameDone pulses. Writing continues (wrap-around, no stop).
- Arithmetic: col/row 9 bits; pixAddr computed as row*COLS + col in 17 bits and registered with pixData.
- Reset mid-byte or mid-frame: everything returns to reset values immediately; no pulse is emitted.

Decomposition:
- Shared package ili9341_pkg:
  - command constants CMD_SWRESET 8'h01, CMD_CASET 8'h2A, CMD_PASET 8'h2B, CMD_RAMWR 8'h2C
  - receiver state enum {IDLE, COL_PARAMS, PAGE_PARAMS, PIX_FIRST, PIX_SECOND, SKIP}
  - COLS/ROWS defaults, shared with the driver
- Sub-module spi_byte_rx: synchronizers, SCK edge detect, shifter, bit counter, byteValid/isData/byteAbort outputs.

Test Plan:
- Reset, then idle CS high for 100 cycles -> all outputs 0, no strobes.
- CASET 00 0A 00 0B; PASET 00 05 00 06; RAMWR; bytes 34 12 78 56 BC 9A F0 DE -> pixWe at pixAddr 1210/0x1234, 1211/0x5678, 1450/0x9ABC, 1451/0xDEF0. frameDone pulses with 1451 only. cmdStrobe pulses 3 times; cmdByte ends at 0x2C.
- Continue with 2 more bytes 11 22 -> pixWe at 1210, pixData 0x2211 (wrap to window start).
- CS low, 5 SCK edges, CS high -> byteAbort pulses once, no cmdStrobe. Next full byte 0x2C decodes correctly.
- CASET 00 F0 00 F5 then RAMWR and 2 bytes -> window unchanged (full). pixWe at pixAddr 0.
- RAMWR, one data byte, then command 0x00 -> no pixWe. Following RAMWR restarts the cursor at the window start; RST_I pulsed mid-byte clears all state.

Source files
------------

// File: rtl/ili9341_pkg.sv
// rtl/ili9341_pkg.sv - ILI9341 command codes, receiver states and panel size shared with the driver
package ili9341_pkg;

   localparam int DEFAULT_COLS = 240;
   localparam int DEFAULT_ROWS = 320;

   localparam logic [7:0] CMD_SWRESET = 8'h01;
   localparam logic [7:0] CMD_CASET   = 8'h2A;
   localparam logic [7:0] CMD_PASET   = 8'h2B;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;

   typedef enum logic [2:0] {
      IDLE,
      COL_PARAMS,
      PAGE_PARAMS,
      PIX_FIRST,
      PIX_SECOND,
      SKIP
   } rxState_e;

endpackage

// File: rtl/spi_byte_rx.sv
// rtl/spi_byte_rx.sv - SPI mode-0 byte deserializer with input synchronizers and abort detection
module spi_byte_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic       tftChipSelect,
   input  logic       tftSck,
   input  logic       tftMosi,
   input  logic       dataCtrl,
   output logic       byteValid,
   output logic [7:0] rxByte,
   output logic       isData,
   output logic       byteAbort
);

   logic [SYNC_STAGES-1:0] csSync, sckSync, mosiSync, dcSync;
   logic       csPrev, sckPrev;
   logic [2:0] bitCnt;
   logic [6:0] shiftReg;
   logic       csS, sckS, mosiS, dcS, sckRise;

   assign csS     = csSync[SYNC_STAGES-1];
   assign sckS    = sckSync[SYNC_STAGES-1];
   assign mosiS   = mosiSync[SYNC_STAGES-1];
   assign dcS     = dcSync[SYNC_STAGES-1];
   assign sckRise = sckS & ~sckPrev;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         // CS sync starts deasserted so an idle bus never looks like a CS edge
         csSync    <= '1;
         sckSync   <= '0;
         mosiSync  <= '0;
         dcSync    <= '0;
         csPrev    <= 1'b1;
         sckPrev   <= 1'b0;
         bitCnt    <= 3'd0;
         shiftReg  <= 7'd0;
         byteValid <= 1'b0;
         rxByte    <= 8'd0;
         isData    <= 1'b0;
         byteAbort <= 1'b0;
      end else begin
         csSync    <= {csSync[SYNC_STAGES-2:0], tftChipSelect};
         sckSync   <= {sckSync[SYNC_STAGES-2:0], tftSck};
         mosiSync  <= {mosiSync[SYNC_STAGES-2:0], tftMosi};
         dcSync    <= {dcSync[SYNC_STAGES-2:0], dataCtrl};
         csPrev    <= csS;
         sckPrev   <= sckS;
         byteValid <= 1'b0;
         byteAbort <= csS && !csPrev && (bitCnt != 3'd0);
         if (csS) begin
            bitCnt   <= 3'd0;
            shiftReg <= 7'd0;
         end else if (sckRise) begin
            shiftReg <= {shiftReg[5:0], mosiS};
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
               rxByte    <= {shiftReg, mosiS};
               isData    <= dcS;
               byteValid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ili9341_spi_receiver.sv
// rtl/ili9341_spi_receiver.sv - ILI9341 command decoder turning RAMWR bytes into framebuffer writes
module ili9341_spi_receiver
   import ili9341_pkg::*;
#(
   parameter int COLS           = DEFAULT_COLS,
   parameter int ROWS           = DEFAULT_ROWS,
   parameter int SYNC_STAGES    = 2,
   parameter int LOW_BYTE_FIRST = 1
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        tftChipSelect,
   input  logic        tftSck,
   input  logic        tftMosi,
   input  logic        dataCtrl,
   output logic        pixWe,
   output logic [16:0] pixAddr,
   output logic [15:0] pixData,
   output logic        cmdStrobe,
   output logic [7:0]  cmdByte,
   output logic        frameDone,
   output logic        byteAbort
);

   localparam logic [8:0]  COL_LAST  = 9'(COLS - 1);
   localparam logic [8:0]  ROW_LAST  = 9'(ROWS - 1);
   localparam logic [15:0] COLS_W    = 16'(COLS);
   localparam logic [15:0] ROWS_W    = 16'(ROWS);
   localparam logic [16:0] COLS_ADDR = 17'(COLS);

   logic       byteValid, isData;
   logic [7:0] rxByte;

   rxState_e   state;
   logic [8:0] startCol, endCol, startRow, endRow, col, row;
   logic [1:0] paramCnt;
   logic [23:0] paramBuf;
   logic [7:0] firstByte;
   logic [15:0] paramStart, paramEnd;
   logic       windowOk;

   spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) byteRx (
      .CLK_I        (CLK_I),
      .RST_I        (RST_I),
      .tftChipSelect(tftChipSelect),
      .tftSck       (tftSck),
      .tftMosi      (tftMosi),
      .dataCtrl     (dataCtrl),
      .byteValid    (byteValid),
      .rxByte       (rxByte),
      .isData       (isData),
      .byteAbort    (byteAbort)
   );

   // Parameter bytes arrive big-endian: {S hi, S lo, E hi, E lo}
   assign paramStart = paramBuf[23:8];
   assign paramEnd   = {paramBuf[7:0], rxByte};
   assign windowOk   = (paramStart <= paramEnd) &&
                       (paramEnd < ((state == COL_PARAMS) ? COLS_W : ROWS_W));

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state     <= IDLE;
         startCol  <= 9'd0;
         endCol    <= COL_LAST;
         startRow  <= 9'd0;
         endRow    <= ROW_LAST;
         col       <= 9'd0;
         row       <= 9'd0;
         paramCnt  <= 2'd0;
         paramBuf  <= 24'd0;
         firstByte <= 8'd0;
         pixWe     <= 1'b0;
         pixAddr   <= 17'd0;
         pixData   <= 16'd0;
         cmdStrobe <= 1'b0;
         cmdByte   <= 8'd0;
         frameDone <= 1'b0;
      end else begin
         pixWe     <= 1'b0;
         cmdStrobe <= 1'b0;
         frameDone <= 1'b0;
         if (byteValid && !isData) begin
            cmdStrobe <= 1'b1;
            cmdByte   <= rxByte;
            paramCnt  <= 2'd0;
            case (rxByte)
               CMD_CASET: state <= COL_PARAMS;
               CMD_PASET: state <= PAGE_PARAMS;
               CMD_RAMWR: begin
                  col   <= startCol;
                  row   <= startRow;
                  state <= PIX_FIRST;
               end
               CMD_SWRESET: begin
                  startCol <= 9'd0;
                  endCol   <= COL_LAST;
                  startRow <= 9'd0;
                  endRow   <= ROW_LAST;
                  state    <= IDLE;
               end
               default: state <= SKIP;
            endcase
         end else if (byteValid) begin
            case (state)
               COL_PARAMS, PAGE_PARAMS: begin
                  if (paramCnt == 2'd3) begin
                     if (windowOk && state == COL_PARAMS) begin
                        startCol <= paramStart[8:0];
                        endCol   <= paramEnd[8:0];
                     end
                     if (windowOk && state == PAGE_PARAMS) begin
                        startRow <= paramStart[8:0];
                        endRow   <= paramEnd[8:0];
                     end
                     state <= IDLE;
                  end else begin
                     paramBuf <= {paramBuf[15:0], rxByte};
                     paramCnt <= paramCnt + 2'd1;
                  end
               end
               PIX_FIRST: begin
                  firstByte <= rxByte;
                  state     <= PIX_SECOND;
               end
               PIX_SECOND: begin
                  pixWe   <= 1'b1;
                  pixData <= (LOW_BYTE_FIRST != 0) ? {rxByte, firstByte} : {firstByte, rxByte};
                  pixAddr <= 17'(row) * COLS_ADDR + 17'(col);
                  if (col == endCol) begin
                     col <= startCol;
                     if (row == endRow) begin
                        row       <= startRow;
                        frameDone <= 1'b1;
                     end else begin
                        row <= row + 9'd1;
                     end
                  end else begin
                     col <= col + 9'd1;
                  end
                  state <= PIX_FIRST;
               end
               default: state <= state;
            endcase
         end
      end
   end

endmodule
